// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Brief    : Generic inter-stage pipeline register with a valid/ready
//             handshake, flush-to-bubble and a global rdy freeze.
//             With PIPE_SKID_EN defined, a second (skid) entry is added so
//             that in_ready is a pure registered-state decode.
//             With PIPE_SKID_EN undefined, the stage holds a single beat and
//             in_ready looks combinationally at out_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W = 128,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // ------------------------------------------------------------------------
    // State encoding doubles as the occupancy count.
    // ------------------------------------------------------------------------
`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1
    } state_t;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
`endif

    logic w_in_fire;
    logic w_out_fire;

    // ------------------------------------------------------------------------
    // Output decode. The head beat always lives in main; main is forced back
    // to BUBBLE whenever the stage empties, the mux just makes that explicit.
    // ------------------------------------------------------------------------
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign occupancy = state_q;

`ifdef PIPE_SKID_EN
    // Upstream ready depends only on held state: the skid slot absorbs the
    // beat that arrives while downstream is stalling.
    assign in_ready  = rst_n & rdy & (state_q != ST_FULL);
`else
    // Single entry: a new beat may only enter if the head leaves this cycle.
    assign in_ready  = rst_n & rdy & (~out_valid | out_ready);
`endif

    assign w_in_fire  = rdy & in_valid & in_ready;
    assign w_out_fire = rdy & out_valid & out_ready;

    // Next-state and next-data selection; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (rdy) begin
            if (flush) begin
                // Any same-cycle in_fire is dropped; an out_fire is still
                // taken by downstream since out_valid was presented.
                state_d = ST_EMPTY;
                main_d  = BUBBLE;
`ifdef PIPE_SKID_EN
                skid_d  = BUBBLE;
`endif
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (w_in_fire) begin
                            state_d = ST_ONE;
                            main_d  = in_data;
                        end
                    end
                    ST_ONE: begin
                        if (w_in_fire && w_out_fire) begin
                            state_d = ST_ONE;
                            main_d  = in_data;
                        end else if (w_in_fire) begin
`ifdef PIPE_SKID_EN
                            // Head is stalled: park the new beat behind it.
                            state_d = ST_FULL;
                            skid_d  = in_data;
`else
                            // Unreachable: in_ready requires out_ready here.
                            state_d = ST_ONE;
`endif
                        end else if (w_out_fire) begin
                            state_d = ST_EMPTY;
                            main_d  = BUBBLE;
                        end
                    end
`ifdef PIPE_SKID_EN
                    ST_FULL: begin
                        // in_ready is low in FULL, so only a drain can occur.
                        if (w_out_fire) begin
                            state_d = ST_ONE;
                            main_d  = skid_q;
                            skid_d  = BUBBLE;
                        end
                    end
`endif
                    default: begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
`ifdef PIPE_SKID_EN
                        skid_d  = BUBBLE;
`endif
                    end
                endcase
            end
        end
    end

    // State and payload registers: async clear, frozen while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
`ifdef PIPE_SKID_EN
            skid_q  <= BUBBLE;
`endif
        end else if (rdy) begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Brief    : Self-checking bench for pipe_stage_reg: directed vector table,
//             hand-written reset/combinational sequences, and randomized
//             traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 16;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int errors = 0;
    int checks = 0;

    // Reference model: the beats currently held, oldest first.
    logic [DW-1:0] model[$];

    typedef struct {
        logic          rdy;
        logic          flush;
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_reg #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic f, input logic iv, input logic [DW-1:0] id,
                                input logic o, input logic eir, input logic eov,
                                input logic [DW-1:0] eod, input logic [1:0] eocc);
        vec_t v;
        v.rdy = r; v.flush = f; v.iv = iv; v.id = id; v.ordy = o;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_occ = eocc;
        vecs.push_back(v);
    endfunction

    // Expected upstream ready from the current model contents and inputs.
    function automatic logic model_ir();
        if (!rst_n || !rdy) return 1'b0;
        if (model.size() < CAP) return 1'b1;
        return (CAP == 1) && out_ready;
    endfunction

    function automatic void model_step();
        logic of;
        logic inf;
        if (rdy) begin
            of  = (model.size() > 0) && out_ready;
            inf = in_valid && model_ir();
            if (flush) begin
                model.delete();
            end else begin
                if (of)  void'(model.pop_front());
                if (inf) model.push_back(in_data);
            end
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".in_ready"},  {15'd0, in_ready},  {15'd0, model_ir()});
        check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, model.size() > 0});
        check({tag, ".out_data"},  out_data, (model.size() > 0) ? model[0] : '0);
        check({tag, ".occupancy"}, {14'd0, occupancy}, DW'(model.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},  {15'd0, in_ready},  '0);
        check({tag, ".out_valid"}, {15'd0, out_valid}, '0);
        check({tag, ".out_data"},  out_data, '0);
        check({tag, ".occupancy"}, {14'd0, occupancy}, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check_reset_outputs("reset_init");
        tick();
        tick();
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        //   rdy flush iv data   ordy | e_ir e_ov e_od  e_occ
        // Streaming
        add(1, 0, 1, 16'h0011, 1,  1, 0, 16'h0000, 0);
        add(1, 0, 1, 16'h0022, 1,  1, 1, 16'h0011, 1);
        add(1, 0, 1, 16'h0033, 1,  1, 1, 16'h0022, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 1, 16'h0033, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
`ifdef PIPE_SKID_EN
        // Backpressure into the skid slot
        add(1, 0, 1, 16'h00A1, 0,  1, 0, 16'h0000, 0);
        add(1, 0, 1, 16'h00A2, 0,  1, 1, 16'h00A1, 1);
        add(1, 0, 1, 16'h00A3, 0,  0, 1, 16'h00A1, 2);
        add(1, 0, 1, 16'h00A3, 1,  0, 1, 16'h00A1, 2);
        add(1, 0, 1, 16'h00A3, 1,  1, 1, 16'h00A2, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 1, 16'h00A3, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
        // Flush while full (0xB5 offered), then flush with a live in_fire
        add(1, 0, 1, 16'h00B1, 0,  1, 0, 16'h0000, 0);
        add(1, 0, 1, 16'h00B2, 0,  1, 1, 16'h00B1, 1);
        add(1, 1, 1, 16'h00B5, 0,  0, 1, 16'h00B1, 2);
        add(1, 0, 1, 16'h00B6, 0,  1, 0, 16'h0000, 0);
        add(1, 1, 1, 16'h00B5, 1,  1, 1, 16'h00B6, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
`else
        // Backpressure with a single entry
        add(1, 0, 1, 16'h00A1, 0,  1, 0, 16'h0000, 0);
        add(1, 0, 1, 16'h00A2, 0,  0, 1, 16'h00A1, 1);
        add(1, 0, 1, 16'h00A2, 1,  1, 1, 16'h00A1, 1);
        add(1, 0, 1, 16'h00A3, 0,  0, 1, 16'h00A2, 1);
        add(1, 0, 1, 16'h00A3, 1,  1, 1, 16'h00A2, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 1, 16'h00A3, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
        // Flush while held, then flush with a live in_fire of 0xB5
        add(1, 0, 1, 16'h00B1, 0,  1, 0, 16'h0000, 0);
        add(1, 1, 1, 16'h00B5, 0,  0, 1, 16'h00B1, 1);
        add(1, 0, 1, 16'h00B6, 0,  1, 0, 16'h0000, 0);
        add(1, 1, 1, 16'h00B5, 1,  1, 1, 16'h00B6, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
`endif
        // rdy freeze with out_ready=1 and flush=1 held
        add(1, 0, 1, 16'h00C7, 0,  1, 0, 16'h0000, 0);
        for (int k = 0; k < 4; k++)
            add(0, 1, 1, 16'h00D0, 1,  0, 1, 16'h00C7, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 1, 16'h00C7, 1);
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rdy = vecs[i].rdy; flush = vecs[i].flush;
            in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d.in_ready", i),  {15'd0, in_ready},  {15'd0, vecs[i].e_ir});
            check($sformatf("vec%0d.out_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].e_ov});
            check($sformatf("vec%0d.out_data", i),  out_data, vecs[i].e_od);
            check($sformatf("vec%0d.occupancy", i), {14'd0, occupancy}, {14'd0, vecs[i].e_occ});
            tick();
        end

        // ---------------- in_ready vs out_ready within one cycle ----------------
        rdy = 1'b1; flush = 1'b0;
        in_valid = 1'b1; in_data = 16'h005A; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        check("comb.ir_stalled", {15'd0, in_ready}, {15'd0, CAP == 2});
        out_ready = 1'b1;
        #1;
        check("comb.ir_released", {15'd0, in_ready}, 16'd1);
        in_valid = 1'b1; in_data = 16'h006B;
        tick();
        check("comb.head_replaced", out_data, 16'h006B);
        check("comb.occ", {14'd0, occupancy}, 16'd1);
        in_valid = 1'b0;
        tick();
        check("comb.drained", {15'd0, out_valid}, 16'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0071;
        tick();
        in_data = 16'h0072;
        tick();
        in_valid = 1'b0;
        #1;
        check("rst.pre_occ", {14'd0, occupancy}, DW'(CAP));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst.async");
        for (int k = 0; k < 3; k++) begin
            tick();
            check_reset_outputs($sformatf("rst.hold%0d", k));
        end
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h0081;
        #1;
        check("rst.first_ir", {15'd0, in_ready}, 16'd1);
        tick();
        check("rst.first_ov", {15'd0, out_valid}, 16'd1);
        check("rst.first_od", out_data, 16'h0081);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("rst.drained", {15'd0, out_valid}, 16'd0);

        // ---------------- randomized traffic vs reference model ----------------
        model.delete();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("rand.reset");
                model.delete();
                tick();
                rst_n = 1'b1;
            end else begin
                rdy       = ($urandom_range(0, 99) < 85);
                flush     = ($urandom_range(0, 99) < 5);
                in_valid  = ($urandom_range(0, 99) < 60);
                in_data   = DW'($urandom);
                out_ready = ($urandom_range(0, 99) < 60);
                #1;
                check_model("rand");
                model_step();
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
